// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, byte-lane writes, fixed response latency.
// The array starts zeroed at time 0; rst never alters its contents.
module dmem_responder #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned MEM_WORDS     = 1024,
    parameter int unsigned LATENCY       = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    input  logic [DATA_WIDTH/8-1:0]  req_be,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     rsp_err
);

    localparam int unsigned BYTES    = DATA_WIDTH / 8;
    localparam int unsigned OFF_BITS = $clog2(BYTES);
    localparam int unsigned IDX_BITS = $clog2(MEM_WORDS);

    // Cycles still to spend in StWait after acceptance; StWait exits when it reaches zero,
    // so rsp_valid rises LATENCY edges after the accepting edge.
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                  state_q;
    logic [3:0]              cnt_q;
    logic                    rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    rsp_err_q;

    logic [DATA_WIDTH-1:0]   mem [MEM_WORDS];

    logic                    accept;
    logic                    misaligned;
    logic                    out_of_range;
    logic                    req_err;
    logic                    do_write;
    logic [IDX_BITS-1:0]     idx;

    initial begin
        for (int unsigned i = 0; i < MEM_WORDS; i++) begin
            mem[i] = '0;
        end
    end

    assign req_ready    = (state_q == StIdle);
    assign accept       = req_valid && req_ready;
    assign misaligned   = (req_addr & ADDRESS_WIDTH'(BYTES - 1)) != '0;
    // Range is judged on the full word address so high address bits cannot alias.
    assign out_of_range = (req_addr >> OFF_BITS) >= ADDRESS_WIDTH'(MEM_WORDS);
    assign req_err      = misaligned || out_of_range;
    assign idx          = req_addr[OFF_BITS +: IDX_BITS];
    assign do_write     = !rst && accept && req_we && !req_err;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Writes commit at the accepting edge; rst never touches the array.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (req_be[b]) begin
                    mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        rsp_err_q   <= req_err;
                        rsp_rdata_q <= (req_err || req_we) ? '0 : mem[idx];
                        cnt_q       <= CNT_INIT;
                        state_q     <= StWait;
                    end
                end
                StWait: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= StResp;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        state_q     <= StIdle;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (default parameters, LATENCY=2).
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int compared   = 0;
    int mismatched = 0;

    dmem_responder dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request, wait for acceptance, measure latency, then complete the handshake.
    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input logic [31:0] exp_rdata, input logic exp_err);
        int n;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'd2);
        check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        check({tag, "_rdata"}, rsp_rdata, exp_rdata);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, "_done"}, {30'd0, rsp_valid, req_ready}, 32'b01);
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        tick();

        do_req("wr_full", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        do_req("rd_full", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
        do_req("wr_lane0", 1'b1, 32'h10, 32'h000000AA, 4'h1, 32'h0, 1'b0);
        do_req("rd_lane0", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0);
        do_req("wr_be0", 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0);
        do_req("rd_be0", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0);
        do_req("rd_misal", 1'b0, 32'h12, 32'h0, 4'h0, 32'h0, 1'b1);
        do_req("wr_oor", 1'b1, 32'h1000, 32'h12345678, 4'hF, 32'h0, 1'b1);
        do_req("rd_word0", 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0);

        // Backpressure: response held while a competing request is presented.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h10;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        check("bp_lat", 32'(n), 32'd2);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h00000055;
        req_be    = 4'hF;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold", {rsp_valid, rsp_err, req_ready, 29'd0}, {3'b100, 29'd0});
            check("bp_rdata", rsp_rdata, 32'hDEADBEAA);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bp_release", {30'd0, rsp_valid, req_ready}, 32'b01);
        do_req("rd_blocked", 1'b0, 32'h20, 32'h0, 4'h0, 32'h0, 1'b0);

        // Reset during WAIT after a write: write persists, no response emerges.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h40;
        req_wdata = 32'h0BADF00D;
        req_be    = 4'hF;
        tick();
        req_valid = 1'b0;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        check("rstw_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rstw_no_rsp", 32'(rsp_valid), 32'd0);
        end
        do_req("rd_after_rst", 1'b0, 32'h40, 32'h0, 4'h0, 32'h0BADF00D, 1'b0);

        // Reset during WAIT after a read: response dropped.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h10;
        tick();
        req_valid = 1'b0;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        check("rstr_ready", 32'(req_ready), 32'd1);
        check("rstr_valid", 32'(rsp_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rstr_no_rsp", 32'(rsp_valid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
